// File: rtl/spm_pkg.sv
// Shared definitions for the spm multiplier family: default operand width,
// product deserializer FSM states and counter sizing.
package spm_pkg;

    localparam int SPM_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic int cnt_width(input int pw);
        return $clog2(pw) + 1;
    endfunction

endpackage

// File: rtl/spm_prod_shreg.sv
// LSB-first assembler for a PW-bit serial product. Stores bits 0..PW-2;
// word presents the full product once the final bit is on din.
module spm_prod_shreg #(
    parameter int PW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          din,
    output logic [PW-1:0] word
);

    logic [PW-2:0] q;

    // clr together with en starts a fresh word with din as bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= en ? {din, {(PW-2){1'b0}}} : '0;
        end else if (en) begin
            q <= {din, q[PW-2:1]};
        end
    end

    assign word = {din, q};

endmodule

// File: rtl/spm_prod_deser.sv
// Deserializes the LSB-first spm product stream into a PW-bit word behind a
// valid/ready handshake. Define SPM_PROD_DESER_PARITY_EN to add prod_par.
module spm_prod_deser
    import spm_pkg::*;
#(
    parameter int WIDTH     = SPM_WIDTH,
    parameter int START_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              y,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [2*WIDTH-1:0] prod,
`ifdef SPM_PROD_DESER_PARITY_EN
    output logic              prod_par,
`endif
    output logic              busy,
    output logic              overrun
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(PW);
    localparam logic [CW-1:0] LAST     = CW'(PW - 1);
    localparam logic [CW-1:0] LAT_LOAD = (START_LAT > 0) ? CW'(START_LAT - 1) : '0;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          sh_clr;
    logic          sh_en;
    logic          load_prod;
    logic          set_ovr;
    logic          begin_cap;
    logic [PW-1:0] word;

    spm_prod_shreg #(.PW(PW)) u_shreg (
        .clk  (clk),
        .rst  (rst),
        .clr  (sh_clr),
        .en   (sh_en),
        .din  (y),
        .word (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            prod    <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load_prod) prod <= word;
            if (set_ovr) overrun <= 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_clr    = 1'b0;
        sh_en     = 1'b0;
        load_prod = 1'b0;
        set_ovr   = 1'b0;
        begin_cap = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin_cap = 1'b1;
            end
            WAIT: begin
                if (start) begin
                    begin_cap = 1'b1;
                end else if (cnt == '0) begin
                    state_n = SHIFT;
                    cnt_n   = CW'(1);
                    sh_clr  = 1'b1;
                    sh_en   = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            SHIFT: begin
                if (start) begin
                    begin_cap = 1'b1;
                end else begin
                    sh_en = 1'b1;
                    if (cnt == LAST) begin
                        state_n   = HOLD;
                        cnt_n     = '0;
                        load_prod = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n   = IDLE;
                    begin_cap = start;
                end else if (start) begin
                    set_ovr = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Any accepted start (including a back-to-back one in HOLD) restarts from bit 0
        if (begin_cap) begin
            sh_clr = 1'b1;
            if (START_LAT == 0) begin
                state_n = SHIFT;
                cnt_n   = CW'(1);
                sh_en   = 1'b1;
            end else begin
                state_n = WAIT;
                cnt_n   = LAT_LOAD;
            end
        end
    end

`ifdef SPM_PROD_DESER_PARITY_EN
    logic par_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_acc  <= 1'b0;
            prod_par <= 1'b0;
        end else begin
            if (sh_clr) par_acc <= sh_en & y;
            else if (sh_en) par_acc <= par_acc ^ y;
            if (load_prod) prod_par <= par_acc ^ y;
        end
    end
`endif

    assign busy      = (state == WAIT) || (state == SHIFT);
    assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_spm_prod_deser.sv
// Self-checking bench: two deserializers (START_LAT 0 and 3) checked every
// cycle against a bit-index model, plus literal checks from the test plan.
module tb_spm_prod_deser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st  [2];
    logic        yb  [2];
    logic        rdy [2];
    logic        ov  [2];
    logic        bz  [2];
    logic        ovr [2];
    logic [63:0] pr  [2];
`ifdef SPM_PROD_DESER_PARITY_EN
    logic        pp  [2];
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    localparam int LAT [2] = '{0, 3};

    always #5 clk = ~clk;

    spm_prod_deser #(.WIDTH(32), .START_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .y(yb[0]), .out_ready(rdy[0]),
        .out_valid(ov[0]), .prod(pr[0]),
`ifdef SPM_PROD_DESER_PARITY_EN
        .prod_par(pp[0]),
`endif
        .busy(bz[0]), .overrun(ovr[0])
    );

    spm_prod_deser #(.WIDTH(32), .START_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .y(yb[1]), .out_ready(rdy[1]),
        .out_valid(ov[1]), .prod(pr[1]),
`ifdef SPM_PROD_DESER_PARITY_EN
        .prod_par(pp[1]),
`endif
        .busy(bz[1]), .overrun(ovr[1])
    );

    // Model: a capture is "bit k arrives LAT cycles + k after start"
    bit          m_act  [2] = '{0, 0};
    bit          m_hold [2] = '{0, 0};
    bit          m_ovr  [2] = '{0, 0};
    bit          m_par  [2] = '{0, 0};
    int          m_age  [2] = '{0, 0};
    logic [63:0] m_acc  [2] = '{64'd0, 64'd0};
    logic [63:0] m_prod [2] = '{64'd0, 64'd0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit go;
            int k;
            go = 1'b0;
            if (rst) begin
                m_act[i] = 0; m_hold[i] = 0; m_ovr[i] = 0; m_par[i] = 0;
                m_age[i] = 0; m_acc[i] = '0; m_prod[i] = '0;
            end else begin
                if (m_hold[i]) begin
                    if (rdy[i]) begin
                        m_hold[i] = 0;
                        go = st[i];
                    end else if (st[i]) begin
                        m_ovr[i] = 1;
                    end
                end else if (st[i]) begin
                    go = 1'b1;
                end
                if (go) begin
                    m_act[i] = 1; m_age[i] = 0; m_acc[i] = '0;
                end
                if (m_act[i]) begin
                    k = m_age[i] - LAT[i];
                    if (k >= 0) m_acc[i][k] = yb[i];
                    if (k == 63) begin
                        m_act[i]  = 0;
                        m_hold[i] = 1;
                        m_prod[i] = m_acc[i];
                        m_par[i]  = ^m_acc[i];
                    end
                    m_age[i]++;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput(i == 0 ? "u0_valid" : "u1_valid", 64'(ov[i]), 64'(m_hold[i]));
                checkOutput(i == 0 ? "u0_busy" : "u1_busy", 64'(bz[i]), 64'(m_act[i]));
                checkOutput(i == 0 ? "u0_overrun" : "u1_overrun", 64'(ovr[i]), 64'(m_ovr[i]));
                checkOutput(i == 0 ? "u0_prod" : "u1_prod", pr[i], m_prod[i]);
`ifdef SPM_PROD_DESER_PARITY_EN
                checkOutput(i == 0 ? "u0_par" : "u1_par", 64'(pp[i]), 64'(m_par[i]));
`endif
            end
        end
    end

    // Drives ncyc cycles of a capture; ack also raises out_ready in the start cycle
    task automatic applyStimulus(input int i, input logic [63:0] w, input bit ack, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == ncyc - 1 && ncyc == LAT[i] + 64)
                checkOutput("early_valid", 64'(ov[i]), 64'd0);
            st[i]  = (c == 0);
            rdy[i] = ack && (c == 0);
            yb[i]  = (c >= LAT[i]) ? w[c - LAT[i]] : 1'b0;
        end
        @(negedge clk);
        st[i] = 1'b0; rdy[i] = 1'b0; yb[i] = 1'b0;
    endtask

    task automatic handshake(input int i);
        @(negedge clk); rdy[i] = 1'b1;
        @(negedge clk); rdy[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; yb[i] = 1'b0; rdy[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("rst_valid", 64'(ov[i]), 64'd0);
            checkOutput("rst_prod", pr[i], 64'd0);
            checkOutput("rst_busy", 64'(bz[i]), 64'd0);
            checkOutput("rst_overrun", 64'(ovr[i]), 64'd0);
        end
        chk_en = 1'b1;

        $display("[TB] basic capture, START_LAT=0");
        applyStimulus(0, 64'h0000_0001_FFFF_FFFE, 1'b0, 64);
        checkOutput("basic_valid", 64'(ov[0]), 64'd1);
        checkOutput("basic_prod", pr[0], 64'h0000_0001_FFFF_FFFE);
        checkOutput("basic_busy", 64'(bz[0]), 64'd0);
        checkOutput("model_pin", m_prod[0], 64'h0000_0001_FFFF_FFFE);
        handshake(0);
        checkOutput("ack_valid", 64'(ov[0]), 64'd0);
        checkOutput("ack_prod_kept", pr[0], 64'h0000_0001_FFFF_FFFE);

        $display("[TB] latency, START_LAT=3");
        applyStimulus(1, 64'h7, 1'b0, 67);
        checkOutput("lat_valid", 64'(ov[1]), 64'd1);
        checkOutput("lat_prod", pr[1], 64'h7);
        handshake(1);

        $display("[TB] back-pressure");
        applyStimulus(0, 64'hA5A5_0000_1234_5678, 1'b0, 64);
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            checkOutput("stall_prod", pr[0], 64'hA5A5_0000_1234_5678);
            checkOutput("stall_valid", 64'(ov[0]), 64'd1);
            st[0] = (s == 5);
        end
        @(negedge clk);
        st[0] = 1'b0;
        checkOutput("stall_overrun", 64'(ovr[0]), 64'd1);
        checkOutput("stall_busy", 64'(bz[0]), 64'd0);
        handshake(0);
        checkOutput("stall_release", 64'(ov[0]), 64'd0);
        checkOutput("stall_idle", 64'(bz[0]), 64'd0);

        $display("[TB] back-to-back");
        applyStimulus(0, 64'h1111_2222_3333_4444, 1'b0, 64);
        applyStimulus(0, 64'hDEAD_BEEF_0123_4567, 1'b1, 64);
        checkOutput("b2b_valid", 64'(ov[0]), 64'd1);
        checkOutput("b2b_prod", pr[0], 64'hDEAD_BEEF_0123_4567);
        handshake(0);

        $display("[TB] abort and reset");
        applyStimulus(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 20);
        applyStimulus(0, 64'h0F0F_0000_8000_0001, 1'b0, 64);
        checkOutput("abort_prod", pr[0], 64'h0F0F_0000_8000_0001);
        handshake(0);
        applyStimulus(0, 64'hFFFF_0000_FFFF_0000, 1'b0, 30);
        checkOutput("mid_busy", 64'(bz[0]), 64'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checkOutput("rst2_valid", 64'(ov[0]), 64'd0);
        checkOutput("rst2_prod", pr[0], 64'd0);
        checkOutput("rst2_busy", 64'(bz[0]), 64'd0);
        checkOutput("rst2_overrun", 64'(ovr[0]), 64'd0);

        $display("[TB] parity products");
        applyStimulus(0, 64'h3, 1'b0, 64);
        checkOutput("p3_prod", pr[0], 64'h3);
`ifdef SPM_PROD_DESER_PARITY_EN
        checkOutput("p3_par", 64'(pp[0]), 64'd0);
`endif
        handshake(0);
        applyStimulus(0, 64'h7, 1'b0, 64);
        checkOutput("p7_prod", pr[0], 64'h7);
`ifdef SPM_PROD_DESER_PARITY_EN
        checkOutput("p7_par", 64'(pp[0]), 64'd1);
`endif
        handshake(0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
